// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: rebuilds 4 BCD digits from a multiplexed 7-seg scan bus.
// Optional BCD->binary converter enabled by defining BCD_TO_BIN_EN.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES  = 1048576,
  parameter bit SCAN_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ScanEn,
  input  logic [7:0]  DataIn,
  output logic [15:0] DataOut,
  output logic [3:0]  DigitErr,
  output logic        FrameValid,
  output logic        ScanLost,
  output logic [13:0] BinOut,
  output logic        BinValid
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CAP_AT  = CW'(STABLE_CYCLES - 2);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [3:0]      scan_s1, scan_s2;
  logic [6:0]      seg_s1, seg_s2;
  logic [3:0]      en, prev_en;
  logic [6:0]      pat, prev_pat;
  logic [CW-1:0]   stab_cnt;
  logic [WW-1:0]   wd_cnt;
  logic            one_hot, adv, capture;
  logic            frame_done, timeout;
  logic [1:0]      idx;
  logic [3:0]      nib;
  logic            nib_err;
  logic [3:0]      mask, mask_nx;
  logic [3:0][3:0] shadow;
  logic [3:0]      err_sh;
  logic            unused_dp;

  // The decimal point never carries digit information.
  assign unused_dp = DataIn[7];

  function automatic logic [4:0] glyph_dec(input logic [6:0] p);
    logic [4:0] r;
    r = 5'h1F;
    unique case (p)
      7'h3F:   r = 5'h00;
      7'h06:   r = 5'h01;
      7'h5B:   r = 5'h02;
      7'h4F:   r = 5'h03;
      7'h66:   r = 5'h04;
      7'h6D:   r = 5'h05;
      7'h7D:   r = 5'h06;
      7'h07:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h6F:   r = 5'h09;
      default: r = 5'h1F;
    endcase
    return r;
  endfunction

  // Two-flop synchroniser for the asynchronous scan bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_s1 <= '0;
      scan_s2 <= '0;
      seg_s1  <= '0;
      seg_s2  <= '0;
    end else begin
      scan_s1 <= ScanEn;
      scan_s2 <= scan_s1;
      seg_s1  <= DataIn[6:0];
      seg_s2  <= seg_s1;
    end
  end

  assign en  = SCAN_ACTIVE_LOW ? ~scan_s2 : scan_s2;
  assign pat = SEG_ACTIVE_LOW  ? ~seg_s2  : seg_s2;

  // One-hot check and digit index of the enabled position.
  always_comb begin
    one_hot = 1'b1;
    idx     = 2'd0;
    case (en)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  assign {nib_err, nib} = glyph_dec(pat);
  assign adv        = one_hot && (en == prev_en) && (pat == prev_pat);
  assign capture    = adv && (stab_cnt == CAP_AT);
  assign frame_done = &mask;
  assign timeout    = !capture && (wd_cnt == WD_LAST);

  // Dwell counter: runs while the same digit shows the same pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_en  <= '0;
      prev_pat <= '0;
      stab_cnt <= '0;
    end else begin
      prev_en  <= en;
      prev_pat <= pat;
      if (!adv)
        stab_cnt <= '0;
      else if (stab_cnt != CNT_MAX)
        stab_cnt <= stab_cnt + CW'(1);
    end
  end

  // Next capture mask: frame end or timeout clears, capture sets.
  always_comb begin
    mask_nx = mask;
    if (frame_done || timeout)
      mask_nx = '0;
    if (capture)
      mask_nx[idx] = 1'b1;
  end

  // Capture mask and per-digit shadow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask   <= '0;
      shadow <= '0;
      err_sh <= '0;
    end else begin
      mask <= mask_nx;
      if (capture) begin
        shadow[idx] <= nib;
        err_sh[idx] <= nib_err;
      end
    end
  end

  // Publish a complete frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DataOut    <= '0;
      DigitErr   <= '0;
      FrameValid <= 1'b0;
    end else begin
      FrameValid <= frame_done;
      if (frame_done) begin
        DataOut  <= shadow;
        DigitErr <= err_sh;
      end
    end
  end

  // Watchdog on capture activity; a capture always beats a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt   <= '0;
      ScanLost <= 1'b0;
    end else if (capture) begin
      wd_cnt   <= '0;
      ScanLost <= 1'b0;
    end else begin
      if (wd_cnt != WD_MAX)
        wd_cnt <= wd_cnt + WW'(1);
      if (timeout)
        ScanLost <= 1'b1;
    end
  end

`ifdef BCD_TO_BIN_EN
  logic        busy;
  logic [1:0]  step;
  logic [13:0] acc, acc_nx;
  logic [3:0]  digit;

  // Digit feed, thousands first.
  always_comb begin
    digit = '0;
    unique case (step)
      2'd0: digit = DataOut[15:12];
      2'd1: digit = DataOut[11:8];
      2'd2: digit = DataOut[7:4];
      2'd3: digit = DataOut[3:0];
    endcase
    acc_nx = acc * 14'd10 + {10'd0, digit};
  end

  // Iterative acc*10+digit conversion, restarted by every new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      step     <= '0;
      acc      <= '0;
      BinOut   <= '0;
      BinValid <= 1'b0;
    end else begin
      BinValid <= 1'b0;
      if (frame_done) begin
        busy <= 1'b1;
        step <= '0;
        acc  <= '0;
      end else if (busy) begin
        if (step == 2'd3) begin
          BinOut   <= (|DigitErr) ? 14'd0 : acc_nx;
          BinValid <= 1'b1;
          busy     <= 1'b0;
        end else begin
          acc  <= acc_nx;
          step <= step + 2'd1;
        end
      end
    end
  end
`else
  assign BinOut   = '0;
  assign BinValid = 1'b0;
`endif

endmodule
